// File: rtl/bolas_inimigas_pool.sv
// bolas_inimigas_pool: pool of falling enemy projectiles with LFSR-gated spawning and ship hit detection.
// Optional BOLA_MIRADA_EN: in-flight projectiles also steer 1 px per tick toward the ship's x.
module bolas_inimigas_pool #(
   parameter int N_BOLAS   = 4,
   parameter int W         = 10,
   parameter int TICK_DIV  = 50000,
   parameter int SPAWN_DIV = 50000000,
   parameter int VEL       = 1,
   parameter int ALTURA    = 480,
   parameter int NAVE_L    = 45,
   parameter int NAVE_A    = 51,
   parameter int PARK      = 1000
) (
   input  logic                 CLOCK_50,
   input  logic                 reset_n,
   input  logic                 pausa,
   input  logic                 reiniciar_jogo,
   input  logic [N_BOLAS*W-1:0] xi,
   input  logic [N_BOLAS*W-1:0] yi,
   input  logic [W-1:0]         x_nave,
   input  logic [W-1:0]         y_nave,
   input  logic [N_BOLAS-1:0]   bola_morta,
   output logic [N_BOLAS*W-1:0] x,
   output logic [N_BOLAS*W-1:0] y,
   output logic [N_BOLAS-1:0]   ativas,
   output logic                 bateunave,
   output logic                 hit_pulse,
   output logic [9:0]           LEDR
);
   localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam int SW = SPAWN_DIV > 1 ? $clog2(SPAWN_DIV) : 1;
   localparam int IW = N_BOLAS > 1 ? $clog2(N_BOLAS) : 1;
   localparam logic [W-1:0] L_PARK = W'(PARK);
   localparam logic [W-1:0] L_ALT  = W'(ALTURA);
   localparam logic [W:0]   L_NL   = (W+1)'(NAVE_L);
   localparam logic [W:0]   L_NA   = (W+1)'(NAVE_A);
   localparam logic [W:0]   L_VEL  = (W+1)'(VEL);
   localparam logic [W:0]   L_MAX  = {1'b0, {W{1'b1}}};

   typedef enum logic {IDLE, FLIGHT} estado_t;

   estado_t       r_st [N_BOLAS];
   logic [W-1:0]  r_x  [N_BOLAS];
   logic [W-1:0]  r_y  [N_BOLAS];
   logic [TW-1:0] r_tick_cnt;
   logic [SW-1:0] r_spawn_cnt;
   logic [3:0]    r_op;
   logic          r_bate;
   logic          r_hit;

   logic               w_tick, w_spawn, w_spawn_ok, w_livre, w_hit_any;
   logic [IW-1:0]      w_sel;
   logic [N_BOLAS-1:0] w_fora, w_dentro;
   logic [W-1:0]       w_x_next [N_BOLAS];
   logic [W-1:0]       w_y_next [N_BOLAS];

   assign w_tick     = !pausa && r_tick_cnt == TW'(TICK_DIV - 1);
   assign w_spawn    = !pausa && r_spawn_cnt == SW'(SPAWN_DIV - 1);
   assign w_spawn_ok = w_spawn && (r_op[2:0] == 3'd1 || r_op[2:0] == 3'd3);
   assign w_hit_any  = w_tick && |(ativas & ~bola_morta & ~w_fora & w_dentro);
   assign bateunave  = r_bate;
   assign hit_pulse  = r_hit;
   assign LEDR       = {6'd0, r_op};

   // Descending scan so the lowest free index is the one left in w_sel.
   always_comb begin
      w_livre = 1'b0;
      w_sel   = '0;
      for (int k = N_BOLAS - 1; k >= 0; k--)
         if (r_st[k] == IDLE && !bola_morta[k]) begin
            w_livre = 1'b1;
            w_sel   = IW'(k);
         end
   end

   for (genvar i = 0; i < N_BOLAS; i++) begin : g_slot
      logic [W:0] w_y_inc;
      assign w_fora[i]   = r_y[i] >= L_ALT;
      assign w_dentro[i] = r_x[i] >= x_nave && {1'b0, r_x[i]} <= {1'b0, x_nave} + L_NL &&
                           r_y[i] >= y_nave && {1'b0, r_y[i]} <= {1'b0, y_nave} + L_NA;
      assign w_y_inc     = {1'b0, r_y[i]} + L_VEL;
      assign w_y_next[i] = w_y_inc > L_MAX ? '1 : w_y_inc[W-1:0];
`ifdef BOLA_MIRADA_EN
      assign w_x_next[i] = r_x[i] < x_nave ? r_x[i] + W'(1) : r_x[i] > x_nave ? r_x[i] - W'(1) : r_x[i];
`else
      assign w_x_next[i] = r_x[i];
`endif
      assign x[i*W +: W] = r_x[i];
      assign y[i*W +: W] = r_y[i];
      assign ativas[i]   = r_st[i] == FLIGHT;
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n)
      if (!reset_n) begin
         r_tick_cnt  <= '0;
         r_spawn_cnt <= '0;
         r_op        <= 4'hF;
         r_bate      <= 1'b0;
         r_hit       <= 1'b0;
         for (int k = 0; k < N_BOLAS; k++) begin
            r_st[k] <= IDLE;
            r_x[k]  <= L_PARK;
            r_y[k]  <= L_PARK;
         end
      end else if (reiniciar_jogo) begin
         r_tick_cnt  <= '0;
         r_spawn_cnt <= '0;
         r_op        <= 4'hF;
         r_bate      <= 1'b0;
         r_hit       <= 1'b0;
         for (int k = 0; k < N_BOLAS; k++) begin
            r_st[k] <= IDLE;
            r_x[k]  <= L_PARK;
            r_y[k]  <= L_PARK;
         end
      end else begin
         if (!pausa) begin
            r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + TW'(1);
            r_spawn_cnt <= w_spawn ? '0 : r_spawn_cnt + SW'(1);
         end
         if (w_spawn)
            r_op <= {r_op[2:0], r_op[3] ^ r_op[2]};
         r_hit  <= w_hit_any;
         r_bate <= r_bate | w_hit_any;
         // Kill is level-sensitive and wins over spawn, pause and movement.
         for (int k = 0; k < N_BOLAS; k++)
            if (bola_morta[k]) begin
               r_st[k] <= IDLE;
               r_x[k]  <= L_PARK;
               r_y[k]  <= L_PARK;
            end else if (w_spawn_ok && w_livre && w_sel == IW'(k)) begin
               r_st[k] <= FLIGHT;
               r_x[k]  <= xi[k*W +: W];
               r_y[k]  <= yi[k*W +: W];
            end else if (w_tick && r_st[k] == FLIGHT) begin
               if (w_fora[k] || w_dentro[k]) begin
                  r_st[k] <= IDLE;
                  r_x[k]  <= L_PARK;
                  r_y[k]  <= L_PARK;
               end else begin
                  r_x[k] <= w_x_next[k];
                  r_y[k] <= w_y_next[k];
               end
            end
      end
endmodule

// File: tb/tb_bolas_inimigas_pool.sv
// tb_bolas_inimigas_pool: directed table, corner sequences and random stimulus against a behavioural model.
// Honours BOLA_MIRADA_EN when defined for the build.
module tb_bolas_inimigas_pool;
   localparam int N = 4;
   localparam int W = 10;
   localparam int PARK = 1000;
   localparam logic [N*W-1:0] PARKV = {N{10'd1000}};

   typedef struct {
      int xi0, yi0, xn, yn, max_y, hit;
   } vec_t;

   logic clk = 1'b0, reset_n = 1'b0, pausa = 1'b0, reiniciar = 1'b0;
   logic [N*W-1:0] xi = '0, yi = '0, x, y;
   logic [W-1:0] x_nave = '0, y_nave = '0;
   logic [N-1:0] bola_morta = '0, ativas;
   logic bateunave, hit_pulse;
   logic [9:0] ledr;

   int n_checks = 0, n_fail = 0;
   int m_x[N], m_y[N];
   bit m_act[N];
   int m_n, m_li;
   bit m_bate, m_hit;
   int seq[15] = '{15, 14, 12, 8, 1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7};

   vec_t tv[6];
   int k, w, maxy, pulses;
   logic [3:0] prev;
   logic [N*W-1:0] sx, sy;
   logic [9:0] sl;

   always #5 clk = ~clk;

   bolas_inimigas_pool #(.N_BOLAS(N), .W(W), .TICK_DIV(2), .SPAWN_DIV(4)) dut (
      .CLOCK_50(clk), .reset_n(reset_n), .pausa(pausa), .reiniciar_jogo(reiniciar),
      .xi(xi), .yi(yi), .x_nave(x_nave), .y_nave(y_nave), .bola_morta(bola_morta),
      .x(x), .y(y), .ativas(ativas), .bateunave(bateunave), .hit_pulse(hit_pulse), .LEDR(ledr)
   );

   task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d t=%0t", nm, got, exp, $time);
      end
   endtask

   function automatic void park(int i);
      m_act[i] = 1'b0;
      m_x[i] = PARK;
      m_y[i] = PARK;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < N; i++) park(i);
      m_n = 0;
      m_li = 0;
      m_bate = 1'b0;
      m_hit = 1'b0;
   endfunction

   // One clock edge of the game rules, applied to the inputs present at that edge.
   function automatic void model_clk();
      bit tick, spawn, hit;
      int s, op, xn, yn;
      if (!reset_n || reiniciar) begin
         model_reset();
         return;
      end
      tick = !pausa && (m_n % 2 == 1);
      spawn = !pausa && (m_n % 4 == 3);
      op = seq[m_li] % 8;
      xn = int'(x_nave);
      yn = int'(y_nave);
      s = -1;
      hit = 1'b0;
      if (spawn && (op == 1 || op == 3))
         for (int i = 0; i < N; i++)
            if (s < 0 && !m_act[i] && !bola_morta[i]) s = i;
      for (int i = 0; i < N; i++)
         if (bola_morta[i]) park(i);
         else if (i == s) begin
            m_act[i] = 1'b1;
            m_x[i] = int'(xi[i*W +: W]);
            m_y[i] = int'(yi[i*W +: W]);
         end else if (tick && m_act[i]) begin
            if (m_y[i] >= 480) park(i);
            else if (m_x[i] >= xn && m_x[i] <= xn + 45 && m_y[i] >= yn && m_y[i] <= yn + 51) begin
               park(i);
               hit = 1'b1;
            end else begin
               m_y[i] = m_y[i] + 1 > 1023 ? 1023 : m_y[i] + 1;
`ifdef BOLA_MIRADA_EN
               if (m_x[i] < xn) m_x[i]++;
               else if (m_x[i] > xn) m_x[i]--;
`endif
            end
         end
      if (spawn) m_li = (m_li + 1) % 15;
      if (!pausa) m_n++;
      m_hit = hit;
      m_bate = m_bate | hit;
   endfunction

   task automatic check_all();
      logic [N*W-1:0] ex, ey;
      logic [N-1:0] ea;
      logic [3:0] eo;
      for (int i = 0; i < N; i++) begin
         ex[i*W +: W] = W'(m_x[i]);
         ey[i*W +: W] = W'(m_y[i]);
         ea[i] = m_act[i];
      end
      eo = 4'(seq[m_li]);
      chk("x", x, ex);
      chk("y", y, ey);
      chk("ativas", ativas, ea);
      chk("hit_pulse", hit_pulse, m_hit);
      chk("bateunave", bateunave, m_bate);
      chk("ledr", ledr, {6'd0, eo});
   endtask

   task automatic step();
      @(posedge clk);
      model_clk();
      @(negedge clk);
      check_all();
   endtask

   task automatic restart();
      reiniciar = 1'b1;
      step();
      reiniciar = 1'b0;
   endtask

   initial begin
      tv[0] = '{100, 470, 300, 200, 480, 0};
      tv[1] = '{310, 150, 300, 200, 200, 1};
      tv[2] = '{345, 190, 300, 200, 200, 1};
      tv[3] = '{320, 251, 300, 200, 251, 1};
      tv[4] = '{320, 252, 300, 200, 480, 0};
      tv[5] = '{1010, 190, 1000, 200, 200, 1};
      model_reset();
      step();
      step();
      reset_n = 1'b1;

      // Single-slot trajectories: only slot 0 may spawn.
      for (int t = 0; t < 6; t++) begin
         restart();
         bola_morta = 4'b1110;
         xi[W-1:0] = W'(tv[t].xi0);
         yi[W-1:0] = W'(tv[t].yi0);
         x_nave = W'(tv[t].xn);
         y_nave = W'(tv[t].yn);
         w = 0;
         while (!ativas[0] && w < 200) begin step(); w++; end
         chk("spawn_wait", ativas[0], 1);
         maxy = 0;
         pulses = 0;
         w = 0;
         while (ativas[0] && w < 1200) begin
            if (int'(y[W-1:0]) > maxy) maxy = int'(y[W-1:0]);
            step();
            if (hit_pulse) pulses++;
            w++;
         end
         chk("retired", ativas[0], 0);
         chk("max_y", maxy, tv[t].max_y);
         step();
         step();
         chk("hit_pulses", pulses, tv[t].hit);
         chk("bateunave_sticky", bateunave, tv[t].hit);
      end
      restart();
      chk("bateunave_cleared", bateunave, 0);

      // LFSR walk from 4'hF through its full period.
      bola_morta = '1;
      chk("lfsr_init", ledr, 10'h00F);
      k = 0;
      w = 0;
      prev = ledr[3:0];
      while (k < 15 && w < 100) begin
         step();
         w++;
         if (ledr[3:0] != prev) begin
            chk("lfsr_seq", ledr[3:0], seq[(k + 1) % 15]);
            prev = ledr[3:0];
            k++;
         end
      end
      chk("lfsr_steps", k, 15);

      // Fill all slots, drop an opportunity, kill slot 2 on a spawn strobe.
      restart();
      bola_morta = '0;
      x_nave = 10'd700;
      y_nave = 10'd700;
      for (int i = 0; i < N; i++) begin
         xi[i*W +: W] = W'(100 * (i + 1));
         yi[i*W +: W] = W'(5 * i);
      end
      for (int i = 0; i < 84; i++) step();
      chk("all_flight", ativas, 4'hF);
      w = 0;
      while (!(m_n % 4 == 3 && (seq[m_li] % 8 == 1 || seq[m_li] % 8 == 3)) && w < 80) begin step(); w++; end
      chk("kill_window", w < 80, 1);
      bola_morta = 4'b0100;
      step();
      chk("kill_vs_spawn", ativas, 4'b1011);
      for (int i = 0; i < 40; i++) step();
      chk("killed_held", ativas, 4'b1011);
      bola_morta = '0;
      w = 0;
      while (!ativas[2] && w < 100) begin step(); w++; end
      chk("respawn_slot2", ativas, 4'hF);
      chk("respawn_x2", x[2*W +: W], 300);

      // Freeze for 20 cycles.
      sx = x;
      sy = y;
      sl = ledr;
      pausa = 1'b1;
      for (int i = 0; i < 20; i++) step();
      chk("pause_x", x, sx);
      chk("pause_y", y, sy);
      chk("pause_lfsr", ledr, sl);
      pausa = 1'b0;
      step();

      // Asynchronous reset in mid-flight.
      #2 reset_n = 1'b0;
      #1;
      chk("arst_x", x, PARKV);
      chk("arst_y", y, PARKV);
      chk("arst_ativas", ativas, 0);
      chk("arst_ledr", ledr, 10'h00F);
      model_reset();
      step();
      reset_n = 1'b1;
      step();

`ifdef BOLA_MIRADA_EN
      restart();
      bola_morta = 4'b1110;
      xi[W-1:0] = 10'd100;
      yi[W-1:0] = 10'd0;
      x_nave = 10'd105;
      y_nave = 10'd700;
      w = 0;
      while (!ativas[0] && w < 200) begin step(); w++; end
      for (int i = 0; i < 11; i++) step();
      chk("aim_reach", x[W-1:0], 105);
      for (int i = 0; i < 10; i++) step();
      chk("aim_hold", x[W-1:0], 105);
`endif

      // Random play against the model.
      restart();
      bola_morta = '0;
      for (int n = 0; n < 4000; n++) begin
         reiniciar = $urandom_range(0, 199) == 0;
         if ($urandom_range(0, 29) == 0) pausa = !pausa;
         for (int i = 0; i < N; i++) bola_morta[i] = $urandom_range(0, 39) == 0;
         if ($urandom_range(0, 19) == 0)
            for (int i = 0; i < N; i++) begin
               xi[i*W +: W] = W'($urandom_range(0, 1023));
               yi[i*W +: W] = W'($urandom_range(380, 500));
            end
         if ($urandom_range(0, 49) == 0) begin
            x_nave = W'($urandom_range(0, 1023));
            y_nave = W'($urandom_range(380, 479));
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
